// File: rtl/uart_pkg.sv
// Shared UART constants: default data width, RX FIFO depth and status-register bit positions.
package uart_pkg;

    localparam int unsigned UART_DATA_W        = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH = 16;

    // Status register bit positions
    localparam int unsigned STAT_RX_READY = 0;
    localparam int unsigned STAT_TX_BUSY  = 1;
    localparam int unsigned STAT_OVERRUN  = 2;
    localparam int unsigned STAT_RX_FULL  = 3;

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int unsigned DATA_W = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: FWFT head, edge-triggered CPU read, threshold interrupt.
// Optional sticky overrun flag built when UART_RX_FIFO_OVERRUN_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int unsigned DATA_W = UART_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_req,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       irq_en,
    input  logic [$clog2(DEPTH):0]     thresh,
`ifdef UART_RX_FIFO_OVERRUN_EN
    output logic                       overrun,
    input  logic                       clr_overrun,
`endif
    output logic                       irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rd_req_q, rd_req_d;
    logic              push, pop;
    logic [CW-1:0]     thresh_eff;
    logic [DATA_W-1:0] ram_rdata;

    // Pop only on a read-strobe rising edge; a pop frees a slot for a same-cycle push
    always_comb begin
        pop      = rd_req && !rd_req_q && (count_q != '0);
        push     = wr_valid && ((count_q != CW'(DEPTH)) || pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        rd_req_d = rd_req;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_req_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rd_req_q <= rd_req_d;
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky drop flag; a new drop beats a same-cycle clear
    always_comb begin
        overrun_d = overrun_q;
        if (wr_valid && !push) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign thresh_eff = (thresh == '0) ? CW'(1) : thresh;
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign rd_data    = empty ? '0 : ram_rdata;
    assign irq        = irq_en && (count_q >= thresh_eff);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue model compared every cycle plus literal spot checks.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          rd_req = 1'b0;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          irq_en = 1'b0;
    logic [CW-1:0] thresh = '0;
    logic          irq;
`ifdef UART_RX_FIFO_OVERRUN_EN
    logic          overrun;
    logic          clr_overrun = 1'b0;
    logic          m_ovr;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .irq_en      (irq_en),
        .thresh      (thresh),
`ifdef UART_RX_FIFO_OVERRUN_EN
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
`endif
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus the previous read-strobe level
    logic [7:0] mq[$];
    logic       m_prev_rd = 1'b0;
    logic       m_valid   = 1'b0;

    always @(posedge clk) begin
        bit do_pop, do_push;
        if (rst) begin
            mq.delete();
            m_prev_rd = 1'b0;
            m_valid   = 1'b1;
`ifdef UART_RX_FIFO_OVERRUN_EN
            m_ovr     = 1'b0;
`endif
        end else begin
            do_pop  = rd_req && !m_prev_rd && (mq.size() > 0);
            do_push = wr_valid && ((mq.size() < DEPTH) || do_pop);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(wr_data);
`ifdef UART_RX_FIFO_OVERRUN_EN
            if (wr_valid && !do_push) m_ovr = 1'b1;
            else if (clr_overrun)     m_ovr = 1'b0;
`endif
            m_prev_rd = rd_req;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int unsigned thr;
        if (m_valid) begin
            thr = (thresh == 0) ? 1 : 32'(thresh);
            chk("m_count",   32'(count),   32'(mq.size()));
            chk("m_empty",   32'(empty),   32'(mq.size() == 0));
            chk("m_full",    32'(full),    32'(mq.size() == DEPTH));
            chk("m_rd_data", 32'(rd_data), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
            chk("m_irq",     32'(irq),     32'(irq_en && (mq.size() >= thr)));
`ifdef UART_RX_FIFO_OVERRUN_EN
            chk("m_overrun", 32'(overrun), 32'(m_ovr));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_rd();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full",  32'(full), 0);
        chk("rst_rdata", 32'(rd_data), 0);
        chk("rst_irq",   32'(irq), 0);

        // Push three bytes and read them back in order
        push(8'h41);
        chk("first_visible", 32'(rd_data), 32'h41);
        push(8'h42);
        push(8'h43);
        chk("cnt3", 32'(count), 3);
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1;
            #1;
            chk("strobe_rdata", 32'(rd_data), 32'h41 + i);
            tick();
            rd_req = 1'b0;
            tick();
        end
        chk("drain_cnt", 32'(count), 0);
        chk("drain_empty", 32'(empty), 1);

        // Fill to DEPTH, then one more is dropped
        for (int i = 1; i <= 17; i++) push(8'(i));
        chk("fill_full", 32'(full), 1);
        chk("fill_cnt", 32'(count), 16);
        chk("fill_head", 32'(rd_data), 1);
`ifdef UART_RX_FIFO_OVERRUN_EN
        chk("ovr_set", 32'(overrun), 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);
`endif

        // Push and pop together while full
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        rd_req   = 1'b1;
        tick();
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        chk("pp_full_cnt", 32'(count), 16);
        chk("pp_full_head", 32'(rd_data), 2);
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("pp_tail", 32'(rd_data), 32'h55);
            pulse_rd();
        end
        chk("pp_drained", 32'(empty), 1);

        // Push and read strobe together while empty: strobe ignored
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        rd_req   = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("pp_empty_cnt", 32'(count), 1);
        chk("pp_empty_rdata", 32'(rd_data), 32'h55);
        rd_req = 1'b0;
        tick();

        // Held strobe pops once
        push(8'h10);
        push(8'h11);
        push(8'h12);
        chk("hold_pre", 32'(count), 4);
        rd_req = 1'b1;
        repeat (10) tick();
        rd_req = 1'b0;
        chk("hold_cnt", 32'(count), 3);
        chk("hold_head", 32'(rd_data), 32'h10);
        tick();

        // Interrupt threshold
        rst = 1'b1;
        tick();
        rst = 1'b0;
        irq_en = 1'b1;
        thresh = 5'd4;
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        chk("irq_below", 32'(irq), 0);
        push(8'hA3);
        chk("irq_at", 32'(irq), 1);
        push(8'hA4);
        irq_en = 1'b0;
        #1;
        chk("irq_dis", 32'(irq), 0);
        irq_en = 1'b1;

        // Reset beats simultaneous push and pop
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        rd_req   = 1'b1;
        tick();
        rst      = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        chk("mrst_cnt", 32'(count), 0);
        chk("mrst_irq", 32'(irq), 0);
        chk("mrst_rdata", 32'(rd_data), 0);

        // Threshold 0 behaves as 1
        thresh = 5'd0;
        #1;
        chk("thr0_empty", 32'(irq), 0);
        push(8'h77);
        chk("thr0_one", 32'(irq), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
